// File: rtl/loader_pkg.sv
// Shared types and default widths for the boot-time program loader.
package loader_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_RUN   = 3'd4
  } state_e;

  // States in which the loader consumes stream bytes.
  function automatic logic is_stream_state(input state_e s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/program_loader.sv
// Framed (length, payload, checksum) byte-stream loader writing RAM from address 0,
// holding the CPU in reset until a frame verifies.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  in_ready_q, in_ready_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  mem_we_q, mem_we_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic [ADDR_WIDTH-1:0] len_in;
  logic                  hs;

  // A length byte of 0 lands as len_q=0, so the last index len_q-1 wraps to
  // the top address and the frame covers the full address space.
  generate
    if (ADDR_WIDTH <= DATA_WIDTH) begin : g_len_trunc
      assign len_in = in_data[ADDR_WIDTH-1:0];
    end else begin : g_len_ext
      assign len_in = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, in_data};
    end
  endgenerate

  assign hs = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      ST_IDLE: begin
        cpu_reset_d = 1'b1;
        if (load) begin
          state_d = ST_LEN;
          error_d = 1'b0;
          done_d  = 1'b0;
          sum_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_LEN: begin
        if (hs) begin
          len_d   = len_in;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (hs) begin
          mem_we_d   = 1'b1;
          mem_addr_d = cnt_q;
          mem_data_d = in_data;
          sum_d      = sum_q + in_data;
          cnt_d      = cnt_q + ADDR_ONE;
          if (cnt_q == len_q - ADDR_ONE) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (hs) begin
          if (in_data == sum_q) begin
            state_d     = ST_RUN;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d     = ST_IDLE;
            error_d     = 1'b1;
            cpu_reset_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Reload over a running program: put the CPU back in reset first.
        if (load) begin
          state_d     = ST_LEN;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          sum_d       = '0;
          cnt_d       = '0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cpu_reset_d = 1'b1;
      end
    endcase

    in_ready_d = is_stream_state(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_we_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_we_q    <= mem_we_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_we    = mem_we_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven frames, random frames
// against a frame-level reference model, and hand-written reset/reload sequences.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_we;
  logic       cpu_reset;
  logic       done;
  logic       error;

  program_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .load(load), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed RAM writes: {addr, data} and the cycle each was seen.
  logic [15:0] wr_q[$];
  int          wr_cyc[$];
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      wr_q.push_back({mem_addr, mem_data});
      wr_cyc.push_back(cyc);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] tx[$];   // whole frame: length, payload, checksum
  logic [7:0] pl[$];   // payload only

  task automatic pulse_load();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
    chk("load_in_ready", in_ready, 1);
    chk("load_cpu_reset", cpu_reset, 1);
    chk("load_done_clr", done, 0);
    chk("load_error_clr", error, 0);
  endtask

  // Drives the first nbytes of tx; returns at the negedge after the last handshake.
  task automatic drive(input int nbytes, input int stall_at, input int stall_len, input bit rnd);
    for (int i = 0; i < nbytes; i++) begin
      if (i == stall_at)
        for (int k = 0; k < stall_len; k++) begin @(negedge clk); in_valid = 1'b0; end
      if (rnd && $urandom_range(0, 3) == 0)
        for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin @(negedge clk); in_valid = 1'b0; end
      @(negedge clk);
      in_data  = tx[i];
      in_valid = 1'b1;
      for (int w = 0; w < 50 && !in_ready; w++) @(negedge clk);
      if (!in_ready) begin
        chk("handshake_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Builds tx from pl with the given length byte and checksum corruption flag.
  task automatic build_tx(input logic [7:0] len_byte, input bit corrupt);
    logic [7:0] s;
    s = 8'h00;
    foreach (pl[i]) s = s + pl[i];
    if (corrupt) s = s ^ 8'(1 + $urandom_range(0, 254));
    tx = {};
    tx.push_back(len_byte);
    foreach (pl[i]) tx.push_back(pl[i]);
    tx.push_back(s);
  endtask

  // Reference model: payload byte i lands at address i, in order; the frame
  // verifies iff the checksum byte equals the payload sum mod 256.
  task automatic check_frame(input string tag, input bit exp_ok, input int exp_gap);
    int n;
    int maxgap;
    n = pl.size();
    chk({tag, "_wr_count"}, wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      if (wr_q[i] !== {i[7:0], pl[i]}) begin
        chk({tag, "_wr_entry"}, wr_q[i], {i[7:0], pl[i]});
        break;
      end
    end
    if (exp_gap > 0 && wr_cyc.size() > 1) begin
      maxgap = 0;
      for (int i = 1; i < wr_cyc.size(); i++)
        if (wr_cyc[i] - wr_cyc[i-1] > maxgap) maxgap = wr_cyc[i] - wr_cyc[i-1];
      chk({tag, "_wr_gap"}, maxgap, exp_gap);
    end
    chk({tag, "_done"}, done, exp_ok);
    chk({tag, "_error"}, error, !exp_ok);
    chk({tag, "_cpu_reset"}, cpu_reset, !exp_ok);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  typedef struct {
    int len;        // 0 means 256
    int pat;        // 0: (i+1)*0x11, 1: 0x01, 2: random
    bit corrupt;
    int stall_at;   // payload index before which in_valid drops, -1 none
    int stall_len;
    bit exp_done;
    bit exp_error;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    vecs[0] = '{3, 0, 1'b0, -1, 0, 1'b1, 1'b0};
    vecs[1] = '{3, 0, 1'b1, -1, 0, 1'b0, 1'b1};
    vecs[2] = '{3, 0, 1'b0, -1, 0, 1'b1, 1'b0};
    vecs[3] = '{0, 1, 1'b0, -1, 0, 1'b1, 1'b0};
    vecs[4] = '{8, 0, 1'b0,  4, 5, 1'b1, 1'b0};
    vecs[5] = '{1, 2, 1'b1, -1, 0, 1'b0, 1'b1};

    reset = 1'b1; load = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle with bytes offered: nothing consumed, CPU held.
    in_valid = 1'b1; in_data = 8'h5a;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    chk("idle_cpu_reset", cpu_reset, 1);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_done", done, 0);
    chk("idle_error", error, 0);
    chk("idle_mem_we", mem_we, 0);
    chk("idle_mem_addr", mem_addr, 0);
    chk("idle_mem_data", mem_data, 0);
    chk("idle_no_writes", wr_q.size(), 0);

    // Literal frame from the plan: 03 11 22 33 66.
    pl = '{8'h11, 8'h22, 8'h33};
    build_tx(8'h03, 1'b0);
    chk("lit_csum", tx[4], 8'h66);
    wr_q = {}; wr_cyc = {};
    pulse_load();
    drive(tx.size(), -1, 0, 1'b0);
    check_frame("lit", 1'b1, 1);

    foreach (vecs[v]) begin
      n = (vecs[v].len == 0) ? 256 : vecs[v].len;
      pl = {};
      for (int i = 0; i < n; i++)
        case (vecs[v].pat)
          0:       pl.push_back(8'((i + 1) * 8'h11));
          1:       pl.push_back(8'h01);
          default: pl.push_back(8'($urandom_range(0, 255)));
        endcase
      build_tx(8'(vecs[v].len), vecs[v].corrupt);
      wr_q = {}; wr_cyc = {};
      pulse_load();
      drive(tx.size(), (vecs[v].stall_at < 0) ? -1 : vecs[v].stall_at + 1, vecs[v].stall_len, 1'b0);
      chk($sformatf("vec%0d_done", v), done, vecs[v].exp_done);
      chk($sformatf("vec%0d_error", v), error, vecs[v].exp_error);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_done,
                  (vecs[v].stall_at < 0) ? 1 : vecs[v].stall_len + 1);
    end

    // Random frames with random gaps against the model.
    for (int r = 0; r < 20; r++) begin
      bit bad;
      n = $urandom_range(1, 40);
      pl = {};
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
      bad = ($urandom_range(0, 3) == 0);
      build_tx(8'(n), bad);
      wr_q = {}; wr_cyc = {};
      pulse_load();
      drive(tx.size(), -1, 0, 1'b1);
      check_frame($sformatf("rnd%0d", r), !bad, 0);
    end

    // Reset during DATA after two payload bytes.
    pl = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee};
    build_tx(8'h05, 1'b0);
    wr_q = {}; wr_cyc = {};
    pulse_load();
    drive(3, -1, 0, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pl = '{8'h10, 8'h20, 8'h30, 8'h40};
    build_tx(8'h04, 1'b0);
    wr_q = {}; wr_cyc = {};
    pulse_load();
    drive(tx.size(), -1, 0, 1'b0);
    check_frame("post_rst", 1'b1, 1);

    // Reload while running; load in LEN must be ignored.
    chk("run_cpu_reset", cpu_reset, 0);
    pl = '{8'h07, 8'h09};
    build_tx(8'h02, 1'b0);
    wr_q = {}; wr_cyc = {};
    pulse_load();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
    chk("len_load_ignored", in_ready, 1);
    drive(tx.size(), -1, 0, 1'b0);
    check_frame("reload", 1'b1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
